// File: rtl/fish_sprite_fetch.sv
// fish_sprite_fetch
// Pixel-pipeline stage in front of the fish-image SRAM (synchronous read,
// one cycle of latency). For every pixel strobe it decides whether the pixel
// falls inside the animated fish sprite. On a hit it issues the SRAM read.
// Two cycles after the strobe it presents an aligned hit/RGB result.
// Key-colour texels are transparent and report no hit.
//
// Pipeline timing, for a pixel strobed in cycle T:
//   T   : hit test and address generation from the shadow registers
//   T+1 : sram_en/sram_addr registered, SRAM samples the address
//   T+2 : sram_data valid, out_valid/out_hit/out_rgb presented

module fish_sprite_fetch #(
  parameter int                SPRITE_W   = 64,
  parameter int                SPRITE_H   = 32,
  parameter int                NUM_FRAMES = 8,
  parameter int                ANIM_DIV   = 4,
  parameter int                ADDR_WIDTH = 16,
  parameter int                DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  frame_tick,
  input  logic [9:0]            fish_x,
  input  logic [9:0]            fish_y,
  input  logic                  fish_dir,
  output logic                  sram_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  out_valid,
  output logic                  out_hit,
  output logic [DATA_WIDTH-1:0] out_rgb
);

  // Counter widths are kept at least one bit wide so that a single-frame
  // or divide-by-one configuration still elaborates cleanly.
  localparam int AIW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int ACW = (ANIM_DIV   > 1) ? $clog2(ANIM_DIV)   : 1;

  localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;

  localparam logic [AIW-1:0] ANIM_IDX_LAST = AIW'(NUM_FRAMES - 1);
  localparam logic [ACW-1:0] ANIM_CNT_LAST = ACW'(ANIM_DIV - 1);

  // Shadow copies of the sprite position and facing. These only change on
  // frame_tick so a frame never mixes two positions.
  logic [9:0]     fx_q;
  logic [9:0]     fy_q;
  logic           dir_q;

  // Animation state: anim_cnt divides frame_tick, anim_idx selects the frame.
  logic [ACW-1:0] anim_cnt;
  logic [AIW-1:0] anim_idx;

  // Pipeline qualifiers.
  logic           v1;
  logic           hit1;
  logic           v2;
  logic           hit2;

  // Stage-0 combinational terms. All position math is done in 11 bits so
  // that fx+SPRITE_W never wraps. A sprite hanging off the right or bottom
  // edge simply never matches there.
  logic [10:0]           px11;
  logic [10:0]           py11;
  logic [10:0]           fx11;
  logic [10:0]           fy11;
  logic [10:0]           dx;
  logic [10:0]           dy;
  logic [10:0]           col;
  logic                  in_x;
  logic                  in_y;
  logic                  hit0;
  logic [31:0]           frame_base;
  logic [31:0]           row_off;
  logic [ADDR_WIDTH-1:0] addr0;

  // Hit test and texel address for the pixel presented this cycle.
  always_comb begin
    px11       = {1'b0, pix_x};
    py11       = {1'b0, pix_y};
    fx11       = {1'b0, fx_q};
    fy11       = {1'b0, fy_q};
    dx         = px11 - fx11;
    dy         = py11 - fy11;
    in_x       = (px11 >= fx11) && (px11 < (fx11 + 11'(SPRITE_W)));
    in_y       = (py11 >= fy11) && (py11 < (fy11 + 11'(SPRITE_H)));
    hit0       = pix_valid && in_x && in_y;
    col        = dir_q ? (11'(SPRITE_W - 1) - dx) : dx;
    frame_base = 32'(anim_idx) * 32'(FRAME_SIZE);
    row_off    = 32'(dy) * 32'(SPRITE_W);
    addr0      = ADDR_WIDTH'(frame_base + row_off + 32'(col));
  end

  // Latch position and facing once per frame. A pixel that arrives in the
  // same cycle as the tick still sees the previous values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fx_q  <= '0;
      fy_q  <= '0;
      dir_q <= 1'b0;
    end else if (frame_tick) begin
      fx_q  <= fish_x;
      fy_q  <= fish_y;
      dir_q <= fish_dir;
    end
  end

  // Step the animation frame every ANIM_DIV frame ticks, wrapping over the
  // stored frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_cnt <= '0;
      anim_idx <= '0;
    end else if (frame_tick) begin
      if (anim_cnt == ANIM_CNT_LAST) begin
        anim_cnt <= '0;
        if (anim_idx == ANIM_IDX_LAST) begin
          anim_idx <= '0;
        end else begin
          anim_idx <= anim_idx + 1'b1;
        end
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // Stage 0 -> 1: issue the SRAM read on a hit. The address is left alone
  // otherwise, which keeps the address bus quiet between sprite pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_en   <= 1'b0;
      sram_addr <= '0;
      v1        <= 1'b0;
      hit1      <= 1'b0;
    end else begin
      sram_en <= hit0;
      v1      <= pix_valid;
      hit1    <= hit0;
      if (hit0) begin
        sram_addr <= addr0;
      end
    end
  end

  // Stage 1 -> 2: carry the qualifiers alongside the SRAM access so that
  // they line up with the returned texel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      v2   <= v1;
      hit2 <= hit1;
    end
  end

  // Stage 2: qualify the returned texel. sram_data is only meaningful when
  // hit2 is set, so it is masked in every other case.
  always_comb begin
    out_valid = v2;
    out_hit   = hit2 && (sram_data != KEY_COLOR);
    out_rgb   = out_hit ? sram_data : '0;
  end

endmodule

// File: tb/tb_fish_sprite_fetch.sv
// Directed bench for fish_sprite_fetch. The bench drives sram_data itself,
// taking the place of the SRAM in the cycle the texel is due.
module tb_fish_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        frame_tick = 1'b0;
  logic [9:0]  fish_x = '0;
  logic [9:0]  fish_y = '0;
  logic        fish_dir = 1'b0;
  logic        sram_en;
  logic [15:0] sram_addr;
  logic [11:0] sram_data = '0;
  logic        out_valid;
  logic        out_hit;
  logic [11:0] out_rgb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fish_sprite_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_tick (frame_tick),
    .fish_x     (fish_x),
    .fish_y     (fish_y),
    .fish_dir   (fish_dir),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .out_rgb    (out_rgb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int x, input int y, input logic dir);
    frame_tick = 1'b1;
    fish_x     = 10'(x);
    fish_y     = 10'(y);
    fish_dir   = dir;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input int x, input int y, input logic dir);
    for (int i = 0; i < n; i++) tick(x, y, dir);
  endtask

  // One isolated pixel: checks the SRAM request at T+1 and the result at T+2.
  task automatic pixel(input string tag, input int x, input int y,
                       input logic exp_en, input int exp_addr,
                       input logic [11:0] data, input logic exp_hit,
                       input logic [11:0] exp_rgb);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk({tag, ".en"},   32'(sram_en),   32'(exp_en));
    chk({tag, ".addr"}, 32'(sram_addr), 32'(exp_addr));
    @(posedge clk); #1;
    sram_data = data;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".hit"},   32'(out_hit),   32'(exp_hit));
    chk({tag, ".rgb"},   32'(out_rgb),   32'(exp_rgb));
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    sram_data = 12'hABC;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".hit"},   32'(out_hit),   32'd0);
    chk({tag, ".rgb"},   32'(out_rgb),   32'd0);
    chk({tag, ".en"},    32'(sram_en),   32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.en",    32'(sram_en),   32'd0);
    chk("rst.addr",  32'(sram_addr), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.hit",   32'(out_hit),   32'd0);
    chk("rst.rgb",   32'(out_rgb),   32'd0);

    // Basic hit, corners and just-outside pixels
    tick(100, 50, 1'b0);
    pixel("p100_50", 100, 50, 1'b1, 0,    12'hABC, 1'b1, 12'hABC);
    pixel("p163_81", 163, 81, 1'b1, 2047, 12'h0F0, 1'b0, 12'h000);
    pixel("p164_81", 164, 81, 1'b0, 2047, 12'hABC, 1'b0, 12'h000);
    pixel("p99_50",   99, 50, 1'b0, 2047, 12'hABC, 1'b0, 12'h000);
    pixel("p100_82", 100, 82, 1'b0, 2047, 12'hABC, 1'b0, 12'h000);
    idle_check("idle0");
    idle_check("idle1");

    // Horizontal mirror
    tick(100, 50, 1'b1);
    pixel("mir100", 100, 50, 1'b1, 63, 12'h123, 1'b1, 12'h123);
    pixel("mir163", 163, 50, 1'b1, 0,  12'h456, 1'b1, 12'h456);

    // Position/facing inputs change without a tick: no effect
    fish_x   = 10'd300;
    fish_y   = 10'd300;
    fish_dir = 1'b0;
    pixel("notear", 100, 50, 1'b1, 63, 12'h789, 1'b1, 12'h789);

    // Animation stepping from a clean reset
    do_reset();
    ticks(3, 100, 50, 1'b0);
    pixel("anim3",  100, 50, 1'b1, 0,     12'h111, 1'b1, 12'h111);
    tick(100, 50, 1'b0);
    pixel("anim4",  100, 50, 1'b1, 2048,  12'h222, 1'b1, 12'h222);
    ticks(24, 100, 50, 1'b0);
    pixel("anim28", 100, 50, 1'b1, 14336, 12'h333, 1'b1, 12'h333);
    ticks(4, 100, 50, 1'b0);
    pixel("anim32", 100, 50, 1'b1, 0,     12'h444, 1'b1, 12'h444);

    // Back-to-back pixels, one per cycle
    pix_valid = 1'b1; pix_x = 10'd100; pix_y = 10'd50;
    @(posedge clk); #1;
    pix_x = 10'd101;
    chk("b2b0.en",   32'(sram_en),   32'd1);
    chk("b2b0.addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    pix_x = 10'd102;
    chk("b2b1.addr", 32'(sram_addr), 32'd1);
    sram_data = 12'hABC; #1;
    chk("b2b0.valid", 32'(out_valid), 32'd1);
    chk("b2b0.rgb",   32'(out_rgb),   32'hABC);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("b2b2.addr", 32'(sram_addr), 32'd2);
    sram_data = 12'h0F0; #1;
    chk("b2b1.valid", 32'(out_valid), 32'd1);
    chk("b2b1.hit",   32'(out_hit),   32'd0);
    chk("b2b1.rgb",   32'(out_rgb),   32'd0);
    @(posedge clk); #1;
    chk("b2b3.en", 32'(sram_en), 32'd0);
    sram_data = 12'h5A5; #1;
    chk("b2b2.valid", 32'(out_valid), 32'd1);
    chk("b2b2.rgb",   32'(out_rgb),   32'h5A5);
    idle_check("b2b_end");

    // Pixel in the same cycle as a tick uses the old shadow values
    pix_valid = 1'b1; pix_x = 10'd100; pix_y = 10'd50;
    frame_tick = 1'b1; fish_x = 10'd200; fish_y = 10'd50; fish_dir = 1'b0;
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_tick = 1'b0;
    chk("same.en",   32'(sram_en),   32'd1);
    chk("same.addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    sram_data = 12'hABC; #1;
    chk("same.hit", 32'(out_hit), 32'd1);
    pixel("newpos_old", 100, 50, 1'b0, 0, 12'hABC, 1'b0, 12'h000);
    pixel("newpos_new", 200, 50, 1'b1, 0, 12'hDEF, 1'b1, 12'hDEF);

    // Sprite hanging off the bottom-right corner
    tick(600, 470, 1'b0);
    pixel("edge639", 639, 479, 1'b1, 615, 12'h777, 1'b1, 12'h777);
    pixel("edge20",   20,   5, 1'b0, 615, 12'h777, 1'b0, 12'h000);

    // Reset while a pixel is in flight
    pix_valid = 1'b1; pix_x = 10'd639; pix_y = 10'd479;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("mid.en_pre", 32'(sram_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid.en_rst", 32'(sram_en), 32'd0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    sram_data = 12'hABC; #1;
    chk("mid.valid2", 32'(out_valid), 32'd0);
    chk("mid.hit2",   32'(out_hit),   32'd0);
    @(posedge clk); #1;
    chk("mid.valid3", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
